// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute, memory and
// writeback, with optional bne/addi decode, a mem_ready wait handshake and illegal-opcode pulse.
module multicycle_control_unit #(
   parameter int ALU_CTRL_W = 3,
   parameter int EN_BNE     = 1,
   parameter int EN_ADDI    = 1,
   parameter int MEM_WAIT   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [5:0]            Opcode,
   input  logic [5:0]            Funct,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  IorD,
   output logic                  MemWrite,
   output logic                  IRWrite,
   output logic                  RegDst,
   output logic                  MemToReg,
   output logic                  RegWrite,
   output logic                  ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            PCSrc,
   output logic                  pc_en,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  illegal,
   output logic [3:0]            state_o
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0] state, next_state;
   logic       ready;
   logic       is_lw, is_sw, is_rtype, is_beq, is_bne, is_addi, is_j, known;
   logic       mem_req_c, irwrite_c, pc_en_c, memwrite_c, regwrite_c, illegal_c;
   logic [2:0] alu_op;

   // With MEM_WAIT=0 the memory is assumed single-cycle and mem_ready is never consulted.
   assign ready    = (MEM_WAIT != 0) ? mem_ready : 1'b1;
   assign is_lw    = (Opcode == OP_LW);
   assign is_sw    = (Opcode == OP_SW);
   assign is_rtype = (Opcode == OP_RTYPE);
   assign is_beq   = (Opcode == OP_BEQ);
   assign is_bne   = (EN_BNE != 0) && (Opcode == OP_BNE);
   assign is_addi  = (EN_ADDI != 0) && (Opcode == OP_ADDI);
   assign is_j     = (Opcode == OP_J);
   assign known    = is_lw | is_sw | is_rtype | is_beq | is_bne | is_addi | is_j;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every reader of state sees the pre-edge value this cycle.
      if (!reset_n) state <= S_FETCH;
      else          state <= next_state;
   end

   always_comb begin
      // NOTE: default first so no path leaves next_state unassigned (no inferred latch).
      next_state = S_FETCH;
      case (state)
         S_FETCH:   next_state = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (is_lw || is_sw)        next_state = S_MEMADR;
            else if (is_rtype)         next_state = S_EXECUTE;
            else if (is_beq || is_bne) next_state = S_BRANCH;
            else if (is_addi)          next_state = S_ADDIEX;
            else if (is_j)             next_state = S_JUMP;
            else                       next_state = S_FETCH;
         end
         S_MEMADR:  next_state = is_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD:   next_state = ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   next_state = ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: next_state = S_ALUWB;
         S_ADDIEX:  next_state = S_ADDIWB;
         default:   next_state = S_FETCH;
      endcase
   end

   always_comb begin
      mem_req_c  = 1'b0;
      irwrite_c  = 1'b0;
      pc_en_c    = 1'b0;
      memwrite_c = 1'b0;
      regwrite_c = 1'b0;
      illegal_c  = 1'b0;
      IorD       = 1'b0;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      alu_op     = 3'b010;
      case (state)
         S_FETCH: begin
            // PC and IR load only on the completing cycle so the PC advances once per fetch.
            mem_req_c = 1'b1;
            irwrite_c = ready;
            pc_en_c   = ready;
            ALUSrcB   = 2'b01;
         end
         S_DECODE: begin
            ALUSrcB   = 2'b11;
            illegal_c = ~known;
         end
         S_MEMADR, S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            mem_req_c = 1'b1;
            IorD      = 1'b1;
         end
         S_MEMWR: begin
            mem_req_c  = 1'b1;
            IorD       = 1'b1;
            memwrite_c = 1'b1;
         end
         S_MEMWB: begin
            regwrite_c = 1'b1;
            MemToReg   = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            case (Funct)
               6'b100010: alu_op = 3'b110;
               6'b100100: alu_op = 3'b000;
               6'b100101: alu_op = 3'b001;
               6'b101010: alu_op = 3'b111;
               default:   alu_op = 3'b010;
            endcase
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            RegDst     = 1'b1;
         end
         S_ADDIWB: regwrite_c = 1'b1;
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            alu_op  = 3'b110;
            PCSrc   = 2'b01;
            pc_en_c = is_bne ? ~zero : zero;
         end
         S_JUMP: begin
            PCSrc   = 2'b10;
            pc_en_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are gated by reset so an abandoned instruction commits nothing.
   assign mem_req  = mem_req_c  & reset_n;
   assign IRWrite  = irwrite_c  & reset_n;
   assign pc_en    = pc_en_c    & reset_n;
   assign MemWrite = memwrite_c & reset_n;
   assign RegWrite = regwrite_c & reset_n;
   assign illegal  = illegal_c  & reset_n;
   assign state_o  = state;

   always_comb begin
      ALUControl      = '0;
      ALUControl[2:0] = alu_op;
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed instruction sequences push expected
// per-cycle outputs; a monitor pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic       pc_en;
      logic [2:0] aluc;
      logic       illegal;
   } outv_t;

   typedef struct {
      int    sel;
      string name;
      outv_t exp;
   } item_t;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   logic       clk, reset_n, zero, mem_ready;
   logic [5:0] opcode, funct;

   logic       a_mem_req, a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite;
   logic       a_alusrca, a_pc_en, a_illegal;
   logic [1:0] a_alusrcb, a_pcsrc;
   logic [2:0] a_aluc;
   logic [3:0] a_state;
   logic       b_mem_req, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite;
   logic       b_alusrca, b_pc_en, b_illegal;
   logic [1:0] b_alusrcb, b_pcsrc;
   logic [2:0] b_aluc;
   logic [3:0] b_state;
   outv_t      act_a, act_b;

   item_t sb[$];
   int    total = 0;
   int    bad   = 0;

   logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
   logic [2:0] alu_tab[6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

   multicycle_control_unit #(.ALU_CTRL_W(3), .EN_BNE(1), .EN_ADDI(1), .MEM_WAIT(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .Opcode(opcode), .Funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(a_mem_req), .IorD(a_iord), .MemWrite(a_memwrite),
      .IRWrite(a_irwrite), .RegDst(a_regdst), .MemToReg(a_memtoreg), .RegWrite(a_regwrite),
      .ALUSrcA(a_alusrca), .ALUSrcB(a_alusrcb), .PCSrc(a_pcsrc), .pc_en(a_pc_en),
      .ALUControl(a_aluc), .illegal(a_illegal), .state_o(a_state)
   );

   multicycle_control_unit #(.ALU_CTRL_W(3), .EN_BNE(0), .EN_ADDI(0), .MEM_WAIT(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .Opcode(opcode), .Funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(b_mem_req), .IorD(b_iord), .MemWrite(b_memwrite),
      .IRWrite(b_irwrite), .RegDst(b_regdst), .MemToReg(b_memtoreg), .RegWrite(b_regwrite),
      .ALUSrcA(b_alusrca), .ALUSrcB(b_alusrcb), .PCSrc(b_pcsrc), .pc_en(b_pc_en),
      .ALUControl(b_aluc), .illegal(b_illegal), .state_o(b_state)
   );

   assign act_a = {a_state, a_mem_req, a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg,
                   a_regwrite, a_alusrca, a_alusrcb, a_pcsrc, a_pc_en, a_aluc, a_illegal};
   assign act_b = {b_state, b_mem_req, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg,
                   b_regwrite, b_alusrca, b_alusrcb, b_pcsrc, b_pc_en, b_aluc, b_illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-written table of the outputs each state presents with mem_ready=1 and a taken branch.
   function automatic outv_t base(input logic [3:0] st);
      outv_t v;
      v      = '0;
      v.st   = st;
      v.aluc = 3'b010;
      case (st)
         4'd0:       begin v.mem_req = 1; v.irwrite = 1; v.pc_en = 1; v.alusrcb = 2'b01; end
         4'd1:       v.alusrcb = 2'b11;
         4'd2, 4'd9: begin v.alusrca = 1; v.alusrcb = 2'b10; end
         4'd3:       begin v.mem_req = 1; v.iord = 1; end
         4'd4:       begin v.regwrite = 1; v.memtoreg = 1; end
         4'd5:       begin v.mem_req = 1; v.iord = 1; v.memwrite = 1; end
         4'd6:       v.alusrca = 1;
         4'd7:       begin v.regwrite = 1; v.regdst = 1; end
         4'd8:       begin v.alusrca = 1; v.aluc = 3'b110; v.pcsrc = 2'b01; v.pc_en = 1; end
         4'd10:      v.regwrite = 1;
         4'd11:      begin v.pcsrc = 2'b10; v.pc_en = 1; end
         default:    ;
      endcase
      return v;
   endfunction

   task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy);
      @(posedge clk);
      #1;
      reset_n   = rst;
      opcode    = op;
      funct     = fn;
      zero      = z;
      mem_ready = rdy;
   endtask

   task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input int sel, input string nm,
                       input outv_t e);
      item_t it;
      drive(rst, op, fn, z, rdy);
      it.sel  = sel;
      it.name = nm;
      it.exp  = e;
      sb.push_back(it);
   endtask

   // Monitor: compares whichever DUT the queued item names, once per cycle at the falling edge.
   initial begin
      item_t it;
      outv_t act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            it  = sb.pop_front();
            act = (it.sel == 1) ? act_b : act_a;
            total++;
            if (act !== it.exp) begin
               bad++;
               $display("FAIL %s: actual=%h required=%h (state %0d vs %0d)",
                        it.name, act, it.exp, act.st, it.exp.st);
            end
         end
      end
   end

   initial begin
      outv_t e;
      reset_n = 1'b0; opcode = RT; funct = '0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);

      e = base(4'd0); e.mem_req = 0; e.irwrite = 0; e.pc_en = 0;
      for (int i = 0; i < 3; i++) step(0, LW, '0, 0, 1, 0, "reset_hold", e);

      // lw, no waits: 0,1,2,3,4
      step(1, LW, '0, 0, 1, 0, "lw_fetch", base(4'd0));
      step(1, LW, '0, 0, 1, 0, "lw_decode", base(4'd1));
      step(1, LW, '0, 0, 1, 0, "lw_memadr", base(4'd2));
      step(1, LW, '0, 0, 1, 0, "lw_memrd", base(4'd3));
      step(1, LW, '0, 0, 1, 0, "lw_memwb", base(4'd4));

      // sw with two wait cycles in MEMWR: 0,1,2,5,5,5
      step(1, SW, '0, 0, 1, 0, "sw_fetch", base(4'd0));
      step(1, SW, '0, 0, 1, 0, "sw_decode", base(4'd1));
      step(1, SW, '0, 0, 1, 0, "sw_memadr", base(4'd2));
      step(1, SW, '0, 0, 0, 0, "sw_memwr_wait1", base(4'd5));
      step(1, SW, '0, 0, 0, 0, "sw_memwr_wait2", base(4'd5));
      step(1, SW, '0, 0, 1, 0, "sw_memwr_done", base(4'd5));

      // R-type funct sweep; the first fetch also exercises one fetch wait cycle.
      e = base(4'd0); e.irwrite = 0; e.pc_en = 0;
      step(1, RT, fn_tab[0], 0, 0, 0, "fetch_wait", e);
      for (int i = 0; i < 6; i++) begin
         step(1, RT, fn_tab[i], 0, 1, 0, $sformatf("rt_fetch_%b", fn_tab[i]), base(4'd0));
         step(1, RT, fn_tab[i], 0, 1, 0, $sformatf("rt_decode_%b", fn_tab[i]), base(4'd1));
         e = base(4'd6); e.aluc = alu_tab[i];
         step(1, RT, fn_tab[i], 0, 1, 0, $sformatf("rt_exec_%b", fn_tab[i]), e);
         step(1, RT, fn_tab[i], 0, 1, 0, $sformatf("rt_aluwb_%b", fn_tab[i]), base(4'd7));
      end

      // Branches: beq/bne with zero both ways.
      for (int i = 0; i < 4; i++) begin
         logic [5:0] op;
         logic       z;
         op = (i < 2) ? BEQ : BNE;
         z  = (i % 2 == 0) ? 1'b1 : 1'b0;
         step(1, op, '0, z, 1, 0, $sformatf("br%0d_fetch", i), base(4'd0));
         step(1, op, '0, z, 1, 0, $sformatf("br%0d_decode", i), base(4'd1));
         e = base(4'd8); e.pc_en = (op == BEQ) ? z : ~z;
         step(1, op, '0, z, 1, 0, $sformatf("br%0d_branch", i), e);
      end

      // addi; mem_ready low outside memory states must not stall.
      step(1, ADDI, '0, 0, 1, 0, "addi_fetch", base(4'd0));
      step(1, ADDI, '0, 0, 0, 0, "addi_decode", base(4'd1));
      step(1, ADDI, '0, 0, 0, 0, "addi_ex", base(4'd9));
      step(1, ADDI, '0, 0, 1, 0, "addi_wb", base(4'd10));

      // j
      step(1, JMP, '0, 0, 1, 0, "j_fetch", base(4'd0));
      step(1, JMP, '0, 0, 1, 0, "j_decode", base(4'd1));
      step(1, JMP, '0, 0, 1, 0, "j_jump", base(4'd11));

      // Undecodable opcode: one-cycle illegal in DECODE, then FETCH.
      step(1, BAD, '0, 0, 1, 0, "bad_fetch", base(4'd0));
      e = base(4'd1); e.illegal = 1;
      step(1, BAD, '0, 0, 1, 0, "bad_decode", e);

      // lw with one MEMRD wait, then reset asserted during MEMWB.
      step(1, LW, '0, 0, 1, 0, "lw2_fetch_after_bad", base(4'd0));
      step(1, LW, '0, 0, 1, 0, "lw2_decode", base(4'd1));
      step(1, LW, '0, 0, 1, 0, "lw2_memadr", base(4'd2));
      step(1, LW, '0, 0, 0, 0, "lw2_memrd_wait", base(4'd3));
      step(1, LW, '0, 0, 1, 0, "lw2_memrd_done", base(4'd3));
      e = base(4'd4); e.regwrite = 0;
      step(0, LW, '0, 0, 1, 0, "lw2_memwb_in_reset", e);
      e = base(4'd0); e.mem_req = 0; e.irwrite = 0; e.pc_en = 0;
      step(0, LW, '0, 0, 1, 0, "lw2_after_reset", e);
      step(1, JMP, '0, 0, 1, 0, "release_fetch", base(4'd0));

      // Second instance: bne/addi disabled decode as illegal.
      drive(0, RT, '0, 0, 1);
      e = base(4'd0); e.mem_req = 0; e.irwrite = 0; e.pc_en = 0;
      step(0, BNE, '0, 1, 1, 1, "b_reset", e);
      step(1, BNE, '0, 1, 1, 1, "b_bne_fetch", base(4'd0));
      e = base(4'd1); e.illegal = 1;
      step(1, BNE, '0, 1, 1, 1, "b_bne_decode", e);
      step(1, ADDI, '0, 0, 1, 1, "b_addi_fetch", base(4'd0));
      step(1, ADDI, '0, 0, 1, 1, "b_addi_decode", e);
      step(1, BEQ, '0, 1, 1, 1, "b_beq_fetch", base(4'd0));
      step(1, BEQ, '0, 1, 1, 1, "b_beq_decode", base(4'd1));
      step(1, BEQ, '0, 1, 1, 1, "b_beq_branch", base(4'd8));
      step(1, RT, '0, 0, 1, 1, "b_fetch_after_beq", base(4'd0));

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multicycle MIPS control unit: a Moore state machine that sequences each instruction over 3–5 cycles through fetch, decode, execute, memory and writeback, driving the shared-memory multicycle datapath. It extends the single-cycle decoder pair with:

- a cycle-by-cycle state machine;
- optional `bne`/`addi` support;
- a wait-state handshake for variable-latency memory;
- an illegal-opcode indication.

It sits between the instruction register (opcode/funct source) and the datapath mux selects and write enables.

## Interface
Parameters:
- ALU_CTRL_W, 3: ALU control width; must be ≥3; bits above [2:0] driven 0.
- EN_BNE, 1: 1 = decode opcode 000101 (bne); 0 = treat it as illegal.
- EN_ADDI, 1: 1 = decode opcode 001000 (addi); 0 = treat it as illegal.
- MEM_WAIT, 1: 1 = honour mem_ready; 0 = mem_ready ignored and treated as 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- Opcode  in  6  instruction[31:26], from the instruction register.
- Funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- mem_req  out  1  memory access active (FETCH, MEMRD, MEMWR).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  register destination: 1 = rd, 0 = rt.
- MemToReg  out  1  writeback data: 1 = memory data, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- PCSrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable.
- ALUControl  out  ALU_CTRL_W  ALU operation.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- state_o  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12–15 are unreachable; if entered, return to FETCH next cycle.
- Transitions:
  - FETCH→DECODE when mem_ready, else hold.
  - DECODE→ by Opcode: lw/sw (100011/101011)→MEMADR; R-type (000000)→EXECUTE; beq (000100), and bne when enabled→BRANCH; addi when enabled→ADDIEX; j (000010)→JUMP.
  - DECODE, any other opcode→FETCH with illegal=1 for that cycle.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB when mem_ready, else hold.
  - MEMWR→FETCH when mem_ready, else hold.
  - EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
- Outputs per state; anything not listed is 0, and ALUControl is 010 unless listed:
  - FETCH: mem_req, IRWrite and pc_en qualified by mem_ready; ALUSrcB=01.
  - DECODE: ALUSrcB=11; computes the branch target into ALUOut.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: mem_req, IorD.
  - MEMWR: mem_req, IorD, MemWrite. MemWrite is held for every wait cycle.
  - MEMWB: RegWrite, MemToReg. ALUWB: RegWrite, RegDst. ADDIWB: RegWrite.
  - EXECUTE: ALUSrcA=1; ALUControl from Funct.
  - BRANCH: ALUSrcA=1, ALUControl=110, PCSrc=01. pc_en = zero for beq, ~zero for bne.
  - JUMP: PCSrc=10, pc_en=1.
- Funct decode in EXECUTE:
  - 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Any other funct→010; the instruction completes normally with no illegal pulse.
- Outputs are a combinational function of the state register plus zero/mem_ready/Opcode. There is no output register.

## Timing
- Reset: on a rising edge with reset_n=0, state←FETCH.
- While reset_n=0, all write enables are forced to 0: IRWrite, pc_en, RegWrite, MemWrite, mem_req. Reset has priority over every transition.
- Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- Cycle counts at zero wait: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- Each wait cycle (mem_ready=0 in FETCH/MEMRD/MEMWR) adds exactly one cycle.
- During wait cycles all outputs except IRWrite/pc_en hold their values.
- IRWrite and pc_en in FETCH are asserted only in the mem_ready cycle, so the PC increments exactly once per fetch.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with mem_ready=1 → state_o=0, pc_en=IRWrite=RegWrite=MemWrite=0. Release → IRWrite=pc_en=1 on the first cycle.
- lw (Opcode 100011), mem_ready=1 → state_o sequence 0,1,2,3,4,0. RegWrite=MemToReg=1 only in state 4. Total 5 cycles.
- sw with mem_ready low for 2 cycles in MEMWR → state_o sequence 0,1,2,5,5,5,0. MemWrite=1 for 3 cycles. RegWrite never asserted.
- beq with zero=1 → pc_en=1 in BRANCH. bne (EN_BNE=1) with zero=1 → pc_en=0. bne with EN_BNE=0 → illegal=1 and return to FETCH after 2 cycles.
- R-type: Funct 101010 → ALUControl=111 in EXECUTE; RegDst=RegWrite=1 in ALUWB. Funct 100010 → ALUControl=110.
- Opcode 111111 → illegal pulses for exactly one cycle in DECODE, next state_o=0, no write enables asserted. Same result for Opcode 001000 with EN_ADDI=0.
